// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - requester, response and shifter signals of the shift sequencer
interface shift_sequencer_if;
  // requester A (ALU issue)
  logic        a_valid;
  logic        a_ready;
  logic [15:0] a_data;
  logic [15:0] a_amt;
  logic        a_lr;
  // requester B (multiply/divide unit)
  logic        b_valid;
  logic        b_ready;
  logic [15:0] b_data;
  logic [15:0] b_amt;
  logic        b_lr;
  // response
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_ov;
  logic        rsp_id;
  // shared barrel shifter
  logic [15:0] shifter_in;
  logic [15:0] shifter_shift;
  logic        shifter_lr;
  logic [15:0] shifter_out;
  logic        shifter_ov;

  modport slave (
    input  a_valid, a_data, a_amt, a_lr,
    output a_ready,
    input  b_valid, b_data, b_amt, b_lr,
    output b_ready,
    output rsp_valid, rsp_data, rsp_ov, rsp_id,
    input  rsp_ready,
    output shifter_in, shifter_shift, shifter_lr,
    input  shifter_out, shifter_ov
  );

  modport master (
    output a_valid, a_data, a_amt, a_lr,
    input  a_ready,
    output b_valid, b_data, b_amt, b_lr,
    input  b_ready,
    input  rsp_valid, rsp_data, rsp_ov, rsp_id,
    output rsp_ready,
    input  shifter_in, shifter_shift, shifter_lr,
    output shifter_out, shifter_ov
  );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - two-port round-robin sequencer for the shared 16-bit barrel shifter
module shift_sequencer #(
  parameter int MAX_STEP = 15
) (
  input logic            clk,
  input logic            reset,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [4:0] STEP_MAX = 5'(MAX_STEP);

  state_t      state;
  state_t      state_nx;
  logic [15:0] acc;
  logic [4:0]  rem;
  logic        ov;
  logic        id;
  logic        lr;
  logic        last_grant;

  logic        grant_a;
  logic        grant_b;
  logic [15:0] sel_data;
  logic [15:0] sel_amt;
  logic        sel_lr;
  logic [4:0]  amt_sat;
  logic [4:0]  step;

  // Round-robin grant; only offered while idle. On a tie the port that did not win last time goes.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE) begin
      if (bus.a_valid && (!bus.b_valid || last_grant)) begin
        grant_a = 1'b1;
      end else if (bus.b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  // Pick the winning request and clamp its amount: 16 or more shifts everything out.
  always_comb begin
    sel_data = grant_b ? bus.b_data : bus.a_data;
    sel_amt  = grant_b ? bus.b_amt  : bus.a_amt;
    sel_lr   = grant_b ? bus.b_lr   : bus.a_lr;
    amt_sat  = (sel_amt[15:4] != 12'd0) ? 5'd16 : {1'b0, sel_amt[3:0]};
  end

  // Positions moved in the current pass.
  always_comb begin
    step = (rem > STEP_MAX) ? STEP_MAX : rem;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nx          = state;
    bus.a_ready       = grant_a;
    bus.b_ready       = grant_b;
    bus.rsp_valid     = 1'b0;
    bus.rsp_data      = 16'd0;
    bus.rsp_ov        = 1'b0;
    bus.rsp_id        = 1'b0;
    bus.shifter_in    = acc;
    bus.shifter_lr    = lr;
    bus.shifter_shift = 16'd0;
    case (state)
      IDLE: begin
        if (grant_a || grant_b) begin
          state_nx = (amt_sat == 5'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        bus.shifter_shift = {11'd0, step};
        if (rem == step) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = acc;
        bus.rsp_ov    = ov;
        bus.rsp_id    = id;
        if (bus.rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath: capture on grant, accumulate one shifter pass per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= 16'd0;
      rem        <= 5'd0;
      ov         <= 1'b0;
      id         <= 1'b0;
      lr         <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            acc        <= sel_data;
            lr         <= sel_lr;
            id         <= grant_b;
            last_grant <= grant_b;
            ov         <= 1'b0;
            rem        <= amt_sat;
          end
        end
        SHIFT: begin
          acc <= bus.shifter_out;
          rem <= rem - step;
          ov  <= ov | bus.shifter_ov;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer
module tb_shift_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_sequencer_if bus();

  shift_sequencer #(.MAX_STEP(15)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural barrel shifter; overflow flags a sign change on left shifts.
  always_comb begin
    if (bus.shifter_lr) begin
      bus.shifter_out = bus.shifter_in << bus.shifter_shift;
    end else begin
      bus.shifter_out = $unsigned($signed(bus.shifter_in) >>> bus.shifter_shift);
    end
    bus.shifter_ov = bus.shifter_lr && (bus.shifter_out[15] != bus.shifter_in[15]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input bit port);
    return port ? bus.b_ready : bus.a_ready;
  endfunction

  task automatic drive(input bit port, input bit v, input logic [15:0] data,
                       input logic [15:0] amt, input bit lr);
    if (!port) begin
      bus.a_valid = v; bus.a_data = data; bus.a_amt = amt; bus.a_lr = lr;
    end else begin
      bus.b_valid = v; bus.b_data = data; bus.b_amt = amt; bus.b_lr = lr;
    end
  endtask

  // One request through to consumed response, rsp_ready held high.
  task automatic send(input string tag, input bit port, input logic [15:0] data,
                      input logic [15:0] amt, input bit lr, input logic [15:0] exp_data,
                      input bit exp_ov, input int exp_passes,
                      input int exp_s0, input int exp_s1);
    int n;
    int lat;
    int passes;
    int s[2];
    bit hi_bad;
    s[0] = 0; s[1] = 0; hi_bad = 0; passes = 0;
    drive(port, 1'b1, data, amt, lr);
    #1;
    n = 0;
    while (!rdy(port) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_grant"}, 32'(rdy(port)), 32'd1);
    tick();
    check({tag, "_ready_one_cycle"}, 32'(rdy(port)), 32'd0);
    drive(port, 1'b0, data, amt, lr);
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      if (bus.shifter_shift != 16'd0) begin
        if (passes < 2) s[passes] = int'(bus.shifter_shift);
        if (bus.shifter_shift[15:4] != 12'd0) hi_bad = 1;
        passes++;
      end
      tick();
      lat++;
    end
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(1 + exp_passes));
    check({tag, "_passes"}, 32'(passes), 32'(exp_passes));
    check({tag, "_step0"}, 32'(s[0]), 32'(exp_s0));
    check({tag, "_step1"}, 32'(s[1]), 32'(exp_s1));
    check({tag, "_shift_hi"}, 32'(hi_bad), 32'd0);
    check({tag, "_data"}, 32'(bus.rsp_data), 32'(exp_data));
    check({tag, "_ov"}, 32'(bus.rsp_ov), 32'(exp_ov));
    check({tag, "_id"}, 32'(bus.rsp_id), 32'(port));
    tick();
    check({tag, "_consumed"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int a_left;
    int b_left;
    int n;
    int order[$];
    int ids[$];
    bit both_seen;
    bit unstable;
    bit seen_rsp;
    int exp_order[6];

    reset = 1'b1;
    drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    check("rst_a_ready", 32'(bus.a_ready), 32'd0);
    check("rst_b_ready", 32'(bus.b_ready), 32'd0);
    check("rst_rsp", {12'd0, bus.rsp_valid, bus.rsp_ov, bus.rsp_id, 1'b0, bus.rsp_data}, 32'd0);
    check("rst_shifter", {15'd0, bus.shifter_lr, bus.shifter_shift | bus.shifter_in}, 32'd0);
    reset = 1'b0;
    tick();

    send("t1", 1'b0, 16'h4000, 16'd1, 1'b1, 16'h8000, 1'b1, 1, 1, 0);
    send("t2", 1'b1, 16'h8010, 16'd4, 1'b0, 16'hF801, 1'b0, 1, 4, 0);

    // Back-to-back contention, both requesters always pending.
    a_left = 3; b_left = 3; both_seen = 0;
    drive(1'b0, 1'b1, 16'h0001, 16'd1, 1'b1);
    drive(1'b1, 1'b1, 16'h0002, 16'd1, 1'b1);
    n = 0;
    while (ids.size() < 6 && n < 60) begin
      #1;
      if (bus.a_ready && bus.b_ready) both_seen = 1;
      if (bus.a_ready) begin order.push_back(0); a_left--; end
      if (bus.b_ready) begin order.push_back(1); b_left--; end
      if (bus.rsp_valid) ids.push_back(int'(bus.rsp_id));
      tick();
      bus.a_valid = (a_left > 0);
      bus.b_valid = (b_left > 0);
      n++;
    end
    exp_order = '{0, 1, 0, 1, 0, 1};
    check("rr_one_grant", 32'(both_seen), 32'd0);
    check("rr_grants", 32'(order.size()), 32'd6);
    check("rr_rsps", 32'(ids.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr_order%0d", i), (i < order.size()) ? 32'(order[i]) : 32'hFFFF, 32'(exp_order[i]));
      check($sformatf("rr_id%0d", i), (i < ids.size()) ? 32'(ids[i]) : 32'hFFFF, 32'(exp_order[i]));
    end
    tick();

    send("t3", 1'b0, 16'h1234, 16'd20, 1'b1, 16'h0000, 1'b0, 2, 15, 1);
    send("t4", 1'b0, 16'h8001, 16'd20, 1'b0, 16'hFFFF, 1'b0, 2, 15, 1);

    // Zero amount with a stalled consumer.
    bus.rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 16'hBEEF, 16'd0, 1'b1);
    #1;
    check("z_grant", 32'(bus.a_ready), 32'd1);
    tick();
    drive(1'b1, 1'b1, 16'h5555, 16'd3, 1'b1);
    check("z_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("z_data", 32'(bus.rsp_data), 32'hBEEF);
    check("z_id_ov", {30'd0, bus.rsp_id, bus.rsp_ov}, 32'd0);
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!bus.rsp_valid || bus.rsp_data != 16'hBEEF || bus.rsp_id || bus.rsp_ov ||
          bus.a_ready || bus.b_ready || bus.shifter_shift != 16'd0) unstable = 1;
    end
    check("z_stall_stable", 32'(unstable), 32'd0);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    check("z_released", 32'(bus.rsp_valid), 32'd0);

    // Reset during the second pass of a 16-position shift.
    drive(1'b0, 1'b1, 16'h1234, 16'd16, 1'b1);
    #1;
    check("r_grant", 32'(bus.a_ready), 32'd1);
    tick();
    bus.a_valid = 1'b0;
    check("r_pass1", 32'(bus.shifter_shift), 32'd15);
    tick();
    check("r_pass2", 32'(bus.shifter_shift), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("r_idle_shift", 32'(bus.shifter_shift), 32'd0);
    seen_rsp = bus.rsp_valid;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.rsp_valid) seen_rsp = 1;
    end
    check("r_no_rsp", 32'(seen_rsp), 32'd0);
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    #1;
    check("r_a_first", {30'd0, bus.a_ready, bus.b_ready}, 32'd2);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Two-requester controller that sequences the 16-bit barrel shifter for the CPU datapath.
- Accepts shift requests of arbitrary 16-bit amount from two sources (port A: ALU issue, port B: multiply/divide unit), arbitrates round-robin, and drives the shared shifter.
- Shift amounts larger than one pass are split into multiple passes of at most MAX_STEP positions; the block accumulates the result and returns it with a sticky overflow flag and requester ID.

Parameters:
- MAX_STEP, 15: maximum positions per shifter pass, legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has a request.
- a_ready  out  1  A request accepted this cycle.
- a_data  in  16  A operand.
- a_amt  in  16  A shift amount (unsigned).
- a_lr  in  1  A direction: 1 = left, 0 = right (arithmetic, sign-fill).
- b_valid, b_ready, b_data, b_amt, b_lr  as A, for requester B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_data  out  16  shifted result.
- rsp_ov  out  1  sticky OR of shifter_ov over all passes.
- rsp_id  out  1  0 = A, 1 = B.
- shifter_in  out  16  operand to shifter.
- shifter_shift  out  16  pass amount; bits [15:4] always 0.
- shifter_lr  out  1  direction to shifter.
- shifter_out  in  16  combinational shifter result.
- shifter_ov  in  1  shifter overflow, left shifts only.

Behaviour:
- States: IDLE, SHIFT, DONE.
- Reset values: state IDLE, acc=0, rem=0, ov=0, id=0, last_grant=B (so A wins first tie). Outputs: a_ready=b_ready=0, rsp_valid=0, rsp_data=0, rsp_ov=0, rsp_id=0, shifter_shift=0, shifter_in=0, shifter_lr=0.
- Reset mid-operation: the in-flight request and any pending response are discarded; no response is issued for it.
- IDLE:
  - a_ready/b_ready are combinational grants, asserted only in IDLE and only to one port.
  - Only one valid: that port is granted.
  - Both valid: grant the port not equal to last_grant.
  - On grant, capture acc=data, lr, id, last_grant=id, ov=0, and rem = min(amt,16). Amounts of 16 or more saturate to 16: left result 0x0000, right result all sign bits.
  - rem==0: go to DONE next cycle with acc unchanged. Otherwise go to SHIFT.
- SHIFT, one pass per cycle:
  - Drive step = min(rem, MAX_STEP), shifter_in=acc, shifter_lr=lr, shifter_shift=step.
  - On the edge: acc=shifter_out, rem=rem-step, ov|=shifter_ov.
  - When rem-step==0, go to DONE.
  - Passes = ceil(rem/MAX_STEP). Default MAX_STEP: amounts 1..15 take 1 pass; 16 and above take 2 passes.
- DONE:
  - rsp_valid=1; rsp_data=acc, rsp_ov=ov, rsp_id=id, all held stable while stalled.
  - When rsp_ready=1, go to IDLE. No new grant occurs in that same cycle.
- Outside SHIFT: shifter_shift=0, shifter_in=acc, shifter_lr=lr.
- Latency, grant edge to rsp_valid high: 1 + passes cycles (amount 0: 1 cycle).
- Throughput: one request per 2 + passes cycles with rsp_ready held high.
- Requesters hold their request until ready; a deasserted valid is never granted.
- rsp_ov is pass-granular: it flags a sign change in any pass, not an arithmetic overflow of the whole shift.

Test Plan:
- A: data 0x4000, amt 1, lr=1. Expect a_ready for 1 cycle; rsp_valid 2 cycles after grant; rsp_data 0x8000, rsp_ov=1, rsp_id=0.
- B: data 0x8010, amt 4, lr=0. Expect rsp_data 0xF801, rsp_ov=0, rsp_id=1, 1 SHIFT pass.
- A: data 0x1234, amt 20, lr=1 (saturated to 16). Expect 2 passes (shifter_shift 15 then 1), rsp_data 0x0000. Same with data 0x8001, lr=0: rsp_data 0xFFFF.
- A and B valid on the same cycle for 3 back-to-back requests each, rsp_ready=1. Expect grant order A, B, A, B, A, B; rsp_id alternates.
- amt 0, data 0xBEEF: rsp_data 0xBEEF 1 cycle after grant, no SHIFT cycles. Hold rsp_ready=0 for 5 cycles: outputs stable, a_ready/b_ready stay 0.
- Assert reset for 1 cycle during the second pass of a 16-position shift. Expect IDLE next cycle, rsp_valid never asserted for that request, and A granted first afterwards.
